// File: rtl/edge_scan_ctrl.sv
// edge_scan_ctrl: raster-scan sequencer that issues one pixel read per pixel and a 3x3 window
// handshake per complete neighbourhood. Define EDGE_SCAN_DIM_CHECK_EN to reject frames smaller than 3x3.
module edge_scan_ctrl #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              clear,
  input  logic [DIM_W-1:0]  img_width,
  input  logic [DIM_W-1:0]  img_height,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  output logic              pix_shift,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DIM_W-1:0]  row,
  output logic [DIM_W-1:0]  col,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, EMIT, DONE} state_t;

  localparam logic [DIM_W-1:0]  DIM_ONE  = DIM_W'(1);
  localparam logic [DIM_W-1:0]  DIM_TWO  = DIM_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [DIM_W-1:0]  width_q, height_q, width_nxt, height_nxt;
  logic [DIM_W-1:0]  row_nxt, col_nxt, row_adv, col_adv;
  logic [ADDR_W-1:0] rd_addr_nxt, wr_addr_nxt;
  logic              launch_q, launch_nxt;
  logic              last_pix, win_pix, dims_ok, col_wrap;

  // A captured start is acted on one cycle later, once the dimensions sit in width_q/height_q.
`ifdef EDGE_SCAN_DIM_CHECK_EN
  assign dims_ok = (width_q >= DIM_W'(3)) && (height_q >= DIM_W'(3));
`else
  assign dims_ok = 1'b1;
`endif

  assign col_wrap = (col == width_q - DIM_ONE);
  assign last_pix = (row == height_q - DIM_ONE) && col_wrap;
  assign win_pix  = (row >= DIM_TWO) && (col >= DIM_TWO);
  assign col_adv  = col_wrap ? '0 : col + DIM_ONE;
  assign row_adv  = col_wrap ? row + DIM_ONE : row;

  assign rd_req    = (state == REQ);
  assign win_valid = (state == EMIT);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign pix_shift = rd_req & rd_ack;

  always_comb begin
    // NOTE: every combinational target gets a default first, so no path can infer a latch.
    state_nxt   = state;
    width_nxt   = width_q;
    height_nxt  = height_q;
    row_nxt     = row;
    col_nxt     = col;
    rd_addr_nxt = rd_addr;
    wr_addr_nxt = wr_addr;
    launch_nxt  = 1'b0;

    case (state)
      IDLE: begin
        if (launch_q) begin
          if (dims_ok) begin
            state_nxt   = REQ;
            row_nxt     = '0;
            col_nxt     = '0;
            rd_addr_nxt = '0;
            wr_addr_nxt = '0;
          end
        end else if (start) begin
          launch_nxt = 1'b1;
          width_nxt  = img_width;
          height_nxt = img_height;
        end
      end
      REQ: begin
        if (rd_ack) begin
          if (win_pix) begin
            state_nxt = EMIT;
          end else if (last_pix) begin
            state_nxt = DONE;
          end else begin
            row_nxt     = row_adv;
            col_nxt     = col_adv;
            rd_addr_nxt = rd_addr + ADDR_ONE;
          end
        end
      end
      EMIT: begin
        // Counters stay on the pixel that completed the window until the window is accepted.
        if (win_ready) begin
          wr_addr_nxt = wr_addr + ADDR_ONE;
          if (last_pix) begin
            state_nxt = DONE;
          end else begin
            state_nxt   = REQ;
            row_nxt     = row_adv;
            col_nxt     = col_adv;
            rd_addr_nxt = rd_addr + ADDR_ONE;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (clear) begin
      state_nxt   = IDLE;
      launch_nxt  = 1'b0;
      row_nxt     = '0;
      col_nxt     = '0;
      rd_addr_nxt = '0;
      wr_addr_nxt = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      width_q  <= '0;
      height_q <= '0;
      row      <= '0;
      col      <= '0;
      rd_addr  <= '0;
      wr_addr  <= '0;
      launch_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      width_q  <= width_nxt;
      height_q <= height_nxt;
      row      <= row_nxt;
      col      <= col_nxt;
      rd_addr  <= rd_addr_nxt;
      wr_addr  <= wr_addr_nxt;
      launch_q <= launch_nxt;
    end
  end

`ifdef EDGE_SCAN_DIM_CHECK_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err <= 1'b0;
    end else begin
      err <= (state == IDLE) && launch_q && !dims_ok && !clear;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: doc/edge_scan_ctrl.md
# edge_scan_ctrl

Raster-scan sequencer for the edge-detection pipeline. It walks an input frame pixel by pixel, issues one read request per pixel to the frame memory, and signals the line-buffer/shift logic when each pixel arrives. Whenever a full 3x3 neighbourhood is available, it presents a window-valid handshake to the Sobel datapath and generates the matching output-image address. Its row and column counters wrap in the style of the team's flexible counter.

## Interface
- DIM_W, 10, width of the frame dimension inputs and the row/column counters
- ADDR_W, 20, width of the input and output memory addresses
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- start  in  1  single-cycle frame start; sampled only in IDLE
- clear  in  1  synchronous abort
- img_width  in  DIM_W  frame width W; latched on accepted start
- img_height  in  DIM_W  frame height H; latched on accepted start
- rd_req  out  1  read request, held until acknowledged
- rd_addr  out  ADDR_W  input pixel address, stable while rd_req is high
- rd_ack  in  1  memory has returned the pixel
- pix_shift  out  1  rd_req & rd_ack; tells the line buffers to shift in the pixel
- win_valid  out  1  3x3 window complete; held until win_ready
- win_ready  in  1  Sobel datapath accepts the window
- wr_addr  out  ADDR_W  output address for the current window
- row, col  out  DIM_W  coordinates of the current pixel
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse at frame end
- err  out  1  single-cycle pulse for a rejected start (macro only)

## Operation
- Reset value of every output is 0, and the FSM resets to IDLE.
- The FSM has four states: IDLE, REQ, EMIT and DONE.
- **IDLE**
  - On start: latch W and H; clear row, col, rd_addr and wr_addr; go to REQ.
- **REQ**
  - rd_req is high.
  - On rd_ack, pix_shift is asserted in the same cycle.
  - If row >= 2 and col >= 2, go to EMIT.
  - Otherwise, if this is the last pixel (row == H-1, col == W-1), go to DONE.
  - Otherwise, advance the counters and stay in REQ.
  - Without rd_ack: hold all state.
- **EMIT**
  - win_valid is high and wr_addr is stable.
  - On win_ready: increment wr_addr.
  - Then, if this is the last pixel, go to DONE; otherwise advance the counters and go to REQ.
- **DONE**
  - Assert done for one cycle, then return to IDLE.
  - rd_addr, wr_addr, row and col keep their final values until the next start.
- **Counter advance**
  - col increments.
  - When col == W-1, col wraps to 0 and row increments.
  - rd_addr increments by 1 on every pixel; it is a running counter, not a row*W multiply.
- **wr_addr**
  - The output image is (W-2)x(H-2), written in raster order.
  - wr_addr for the window centred at (r-1, c-1) equals the count of windows already accepted.
- **Arithmetic:** counters are unsigned. rd_addr and wr_addr are ADDR_W bits wide and wrap modulo 2^ADDR_W without a flag.
- **clear**
  - Clear forces IDLE, zeroes all counters and drops rd_req and win_valid next cycle.
  - done is not pulsed.
  - Clear has priority over start, rd_ack and win_ready in the same cycle.
- **start when not in IDLE:** ignored; latched dimensions do not change.
- **Reset mid-frame:** immediate return to IDLE with all outputs at 0.

## Timing
- start to first rd_req: 1 cycle (start sampled at edge n, rd_req high after edge n+1).
- With rd_ack tied high, each pixel takes 1 cycle, and each window adds 1 EMIT cycle.
- Frame length = W*H + (W-2)(H-2) + 1 cycles from the first REQ cycle through DONE, with zero stalls.
- done rises 1 cycle after the final handshake (rd_ack or win_ready) completes.
- win_valid and wr_addr must not change while win_valid=1 and win_ready=0.

## Configuration
- Macro: EDGE_SCAN_DIM_CHECK_EN.
- Defined:
  - start with W < 3 or H < 3 is rejected.
  - err pulses 1 cycle after start and the FSM stays in IDLE.
  - busy is never asserted for a rejected start.
- Undefined:
  - No dimension check; err is tied to 0.
  - Frames with W < 3 or H < 3 perform all W*H reads, emit no windows, and then pulse done.
  - W = 0 or H = 0 is unsupported.

## Test plan
- **4x3 frame, rd_ack=1, win_ready=1, no stalls**
  - rd_addr runs 0..11.
  - win_valid is high after pixels (2,2) and (2,3), with wr_addr 0 and then 1.
  - done pulses on cycle 15 after the start edge.
- **5x5 frame, rd_ack low 3 cycles on pixel 7**
  - rd_req and rd_addr=7 are held for those 3 cycles.
  - pix_shift pulses exactly once per pixel (25 total).
- **5x4 frame, win_ready low 4 cycles on the first window**
  - win_valid and wr_addr=0 are held stable.
  - No rd_req is issued during the stall.
  - 6 windows are accepted in total.
- **Mid-frame clear at pixel 9, with start in the same cycle**
  - Returns to IDLE with all outputs 0 and no done pulse.
  - The start in the clear cycle is ignored.
  - A new 3x3 frame afterwards completes with exactly one window.
- **Reset asserted mid-EMIT**
  - win_valid and busy drop immediately.
  - After release, the FSM is in IDLE.
- **start with W=2, H=5**
  - With EDGE_SCAN_DIM_CHECK_EN: err pulses and no reads occur.
  - Without it: 10 reads, 0 windows, then done.
